// File: rtl/data_bus_arbiter.sv
// Two-master data bus arbiter: CPU load/store unit (master 0) vs UART debug port (master 1).
// Ownership changes only at transfer boundaries and always pass through a one-cycle idle turnaround.
module data_bus_arbiter #(
    parameter int unsigned IDLE_RELEASE = 4,
    parameter int unsigned MAX_HOLD     = 64,
    parameter int unsigned CNT_WIDTH    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cpu_address,
    input  logic [31:0] cpu_write_data,
    input  logic [1:0]  cpu_mode,
    input  logic [1:0]  cpu_reqw,
    input  logic        cpu_reqs,
    input  logic        cpu_stall_lw,
    output logic [31:0] cpu_read_data,
    output logic        cpu_stall,
    input  logic [31:0] dbg_address,
    input  logic [31:0] dbg_write_data,
    input  logic [1:0]  dbg_mode,
    input  logic [1:0]  dbg_reqw,
    input  logic        dbg_reqs,
    input  logic        dbg_stall_lw,
    output logic [31:0] dbg_read_data,
    input  logic        dbg_halted,
    output logic        dbg_grant,
    output logic [31:0] bus_address,
    output logic [31:0] bus_write_data,
    output logic [1:0]  bus_mode,
    output logic [1:0]  bus_reqw,
    output logic        bus_reqs,
    output logic        bus_stall_lw,
    input  logic [31:0] bus_read_data,
    output logic        owner
);

    localparam logic [1:0] OWN_CPU  = 2'd0;
    localparam logic [1:0] HANDOVER = 2'd1;
    localparam logic [1:0] OWN_DBG  = 2'd2;

    localparam logic [1:0] MODE_IDLE  = 2'b00;
    localparam logic [1:0] MODE_READ  = 2'b01;
    localparam logic [1:0] MODE_WRITE = 2'b10;

    localparam logic [CNT_WIDTH-1:0] IDLE_LAST = CNT_WIDTH'(IDLE_RELEASE - 1);
    localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(MAX_HOLD - 1);

    logic [1:0]           r_state;
    logic                 r_target;
    logic                 r_rd_phase;
    logic [CNT_WIDTH-1:0] r_idle_cnt;
    logic [CNT_WIDTH-1:0] r_hold_cnt;

    logic [1:0]           w_state_nxt;
    logic                 w_target_nxt;
    logic                 w_rd_phase_nxt;
    logic [CNT_WIDTH-1:0] w_idle_cnt_nxt;
    logic [CNT_WIDTH-1:0] w_hold_cnt_nxt;

    logic [1:0]           w_own_mode;
    logic                 w_switchable;
    logic                 w_sel_dbg;
    logic                 w_dbg_wants;
    logic                 w_release;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    // Mode of whichever master currently drives the bus; idle during turnaround.
    always_comb begin
        case (r_state)
            OWN_CPU: w_own_mode = cpu_mode;
            OWN_DBG: w_own_mode = dbg_mode;
            default: w_own_mode = MODE_IDLE;
        endcase
    end

    assign w_switchable = (w_own_mode == MODE_IDLE) || (w_own_mode == MODE_WRITE) || r_rd_phase;
    assign w_dbg_wants  = (dbg_mode != MODE_IDLE) || dbg_halted;
    assign w_release    = !dbg_halted && w_switchable &&
                          (((r_idle_cnt == IDLE_LAST) && (dbg_mode == MODE_IDLE)) ||
                           (r_hold_cnt >= HOLD_LAST));

    always_comb begin
        w_state_nxt    = r_state;
        w_target_nxt   = r_target;
        w_rd_phase_nxt = 1'b0;
        w_idle_cnt_nxt = '0;
        w_hold_cnt_nxt = '0;
        case (r_state)
            OWN_CPU: begin
                w_rd_phase_nxt = !r_rd_phase && (cpu_mode == MODE_READ);
                if (w_dbg_wants && w_switchable) begin
                    w_state_nxt    = HANDOVER;
                    w_target_nxt   = 1'b1;
                    w_rd_phase_nxt = 1'b0;
                end
            end
            HANDOVER: begin
                w_state_nxt = r_target ? OWN_DBG : OWN_CPU;
            end
            OWN_DBG: begin
                w_rd_phase_nxt = !r_rd_phase && (dbg_mode == MODE_READ);
                if ((dbg_mode == MODE_IDLE) && !dbg_halted)
                    w_idle_cnt_nxt = sat_inc(r_idle_cnt);
                if ((cpu_mode != MODE_IDLE) && !dbg_halted)
                    w_hold_cnt_nxt = sat_inc(r_hold_cnt);
                if (w_release) begin
                    w_state_nxt    = HANDOVER;
                    w_target_nxt   = 1'b0;
                    w_rd_phase_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt  = OWN_CPU;
                w_target_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= OWN_CPU;
            r_target   <= 1'b0;
            r_rd_phase <= 1'b0;
            r_idle_cnt <= '0;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_target   <= w_target_nxt;
            r_rd_phase <= w_rd_phase_nxt;
            r_idle_cnt <= w_idle_cnt_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
        end
    end

    // During turnaround the address/data/width already point at the incoming owner.
    always_comb begin
        case (r_state)
            OWN_DBG:  w_sel_dbg = 1'b1;
            HANDOVER: w_sel_dbg = r_target;
            default:  w_sel_dbg = 1'b0;
        endcase
    end

    always_comb begin
        bus_address    = w_sel_dbg ? dbg_address    : cpu_address;
        bus_write_data = w_sel_dbg ? dbg_write_data : cpu_write_data;
        bus_reqw       = w_sel_dbg ? dbg_reqw       : cpu_reqw;
        bus_reqs       = w_sel_dbg ? dbg_reqs       : cpu_reqs;
        bus_mode       = MODE_IDLE;
        bus_stall_lw   = 1'b0;
        cpu_read_data  = '0;
        dbg_read_data  = '0;
        case (r_state)
            OWN_CPU: begin
                bus_mode      = cpu_mode;
                bus_stall_lw  = cpu_stall_lw;
                cpu_read_data = bus_read_data;
            end
            OWN_DBG: begin
                bus_mode      = dbg_mode;
                bus_stall_lw  = dbg_stall_lw;
                dbg_read_data = bus_read_data;
            end
            default: ;
        endcase
    end

    assign owner     = (r_state == OWN_DBG);
    assign dbg_grant = (r_state == OWN_DBG);
    assign cpu_stall = (cpu_mode != MODE_IDLE) && (r_state != OWN_CPU);

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed self-checking bench for data_bus_arbiter: reset, takeover, read integrity,
// idle release, starvation limit, halted hold and asynchronous reset.
module tb_data_bus_arbiter;

    logic        clk;
    logic        reset;
    logic [31:0] cpu_address, cpu_write_data, cpu_read_data;
    logic [1:0]  cpu_mode, cpu_reqw;
    logic        cpu_reqs, cpu_stall_lw, cpu_stall;
    logic [31:0] dbg_address, dbg_write_data, dbg_read_data;
    logic [1:0]  dbg_mode, dbg_reqw;
    logic        dbg_reqs, dbg_stall_lw, dbg_halted, dbg_grant;
    logic [31:0] bus_address, bus_write_data, bus_read_data;
    logic [1:0]  bus_mode, bus_reqw;
    logic        bus_reqs, bus_stall_lw, owner;

    int checks = 0;
    int errors = 0;

    data_bus_arbiter #(.IDLE_RELEASE(4), .MAX_HOLD(64), .CNT_WIDTH(8)) dut (
        .clk(clk), .reset(reset),
        .cpu_address(cpu_address), .cpu_write_data(cpu_write_data), .cpu_mode(cpu_mode),
        .cpu_reqw(cpu_reqw), .cpu_reqs(cpu_reqs), .cpu_stall_lw(cpu_stall_lw),
        .cpu_read_data(cpu_read_data), .cpu_stall(cpu_stall),
        .dbg_address(dbg_address), .dbg_write_data(dbg_write_data), .dbg_mode(dbg_mode),
        .dbg_reqw(dbg_reqw), .dbg_reqs(dbg_reqs), .dbg_stall_lw(dbg_stall_lw),
        .dbg_read_data(dbg_read_data), .dbg_halted(dbg_halted), .dbg_grant(dbg_grant),
        .bus_address(bus_address), .bus_write_data(bus_write_data), .bus_mode(bus_mode),
        .bus_reqw(bus_reqw), .bus_reqs(bus_reqs), .bus_stall_lw(bus_stall_lw),
        .bus_read_data(bus_read_data), .owner(owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs for the new cycle are driven here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        cpu_address = '0; cpu_write_data = '0; cpu_mode = 2'b00; cpu_reqw = 2'b00;
        cpu_reqs = 1'b0; cpu_stall_lw = 1'b0;
        dbg_address = '0; dbg_write_data = '0; dbg_mode = 2'b00; dbg_reqw = 2'b00;
        dbg_reqs = 1'b0; dbg_stall_lw = 1'b0; dbg_halted = 1'b0;
        bus_read_data = '0;

        // Asynchronous reset with a CPU read pending, before any clock edge.
        #2;
        cpu_mode = 2'b01; cpu_address = 32'h100; reset = 1'b1;
        #1;
        chk("rst_owner", {31'b0, owner}, 32'd0);
        chk("rst_grant", {31'b0, dbg_grant}, 32'd0);
        chk("rst_bus_mode", {30'b0, bus_mode}, 32'd1);
        chk("rst_bus_addr", bus_address, 32'h100);
        chk("rst_cpu_stall", {31'b0, cpu_stall}, 32'd0);
        chk("rst_dbg_rdata", dbg_read_data, 32'd0);
        tick();
        tick();

        // Idle takeover: cycle T0 in OWN_CPU, T1 HANDOVER, T2..T3 debug read.
        reset = 1'b0; cpu_mode = 2'b00;
        dbg_mode = 2'b01; dbg_address = 32'h2000; bus_read_data = 32'hDEADBEEF;
        #1;
        chk("tk0_owner", {31'b0, owner}, 32'd0);
        chk("tk0_bus_mode", {30'b0, bus_mode}, 32'd0);
        tick();
        chk("tk1_bus_mode", {30'b0, bus_mode}, 32'd0);
        chk("tk1_owner", {31'b0, owner}, 32'd0);
        chk("tk1_dbg_rdata", dbg_read_data, 32'd0);
        chk("tk1_cpu_rdata", cpu_read_data, 32'd0);
        chk("tk1_bus_addr", bus_address, 32'h2000);
        tick();
        chk("tk2_bus_mode", {30'b0, bus_mode}, 32'd1);
        chk("tk2_bus_addr", bus_address, 32'h2000);
        chk("tk2_dbg_rdata", dbg_read_data, 32'hDEADBEEF);
        chk("tk2_grant", {31'b0, dbg_grant}, 32'd1);
        chk("tk2_cpu_rdata", cpu_read_data, 32'd0);
        tick();
        chk("tk3_bus_mode", {30'b0, bus_mode}, 32'd1);
        chk("tk3_dbg_rdata", dbg_read_data, 32'hDEADBEEF);
        chk("tk3_owner", {31'b0, owner}, 32'd1);

        // Idle release: four idle debug cycles, then HANDOVER, then CPU.
        for (int i = 0; i < 4; i++) begin
            tick();
            dbg_mode = 2'b00;
            #1;
            chk("idle_hold_owner", {31'b0, owner}, 32'd1);
        end
        tick();
        chk("idle_ho_owner", {31'b0, owner}, 32'd0);
        chk("idle_ho_grant", {31'b0, dbg_grant}, 32'd0);
        chk("idle_ho_bus_mode", {30'b0, bus_mode}, 32'd0);
        tick();
        chk("idle_cpu_owner", {31'b0, owner}, 32'd0);

        // No read split: CPU read and debug write begin together.
        tick();
        cpu_mode = 2'b01; cpu_address = 32'h300; bus_read_data = 32'h12345678;
        dbg_mode = 2'b10; dbg_address = 32'h400; dbg_write_data = 32'hCAFE0001;
        #1;
        chk("rs_a_bus_mode", {30'b0, bus_mode}, 32'd1);
        chk("rs_a_bus_addr", bus_address, 32'h300);
        chk("rs_a_cpu_stall", {31'b0, cpu_stall}, 32'd0);
        tick();
        chk("rs_b_bus_mode", {30'b0, bus_mode}, 32'd1);
        chk("rs_b_cpu_stall", {31'b0, cpu_stall}, 32'd0);
        chk("rs_b_cpu_rdata", cpu_read_data, 32'h12345678);
        chk("rs_b_owner", {31'b0, owner}, 32'd0);
        tick();
        cpu_mode = 2'b00;
        #1;
        chk("rs_c_bus_mode", {30'b0, bus_mode}, 32'd0);
        chk("rs_c_bus_addr", bus_address, 32'h400);
        chk("rs_c_owner", {31'b0, owner}, 32'd0);

        // Starvation: debug writes back-to-back while the CPU waits; 64 owned cycles.
        tick();
        cpu_mode = 2'b10; cpu_address = 32'h500;
        #1;
        chk("rs_d_bus_mode", {30'b0, bus_mode}, 32'd2);
        chk("rs_d_bus_wdata", bus_write_data, 32'hCAFE0001);
        chk("rs_d_grant", {31'b0, dbg_grant}, 32'd1);
        chk("sv_cpu_stall0", {31'b0, cpu_stall}, 32'd1);
        for (int i = 1; i < 64; i++) begin
            tick();
            chk("sv_owner", {31'b0, owner}, 32'd1);
            chk("sv_cpu_stall", {31'b0, cpu_stall}, 32'd1);
        end
        tick();
        chk("sv_ho_owner", {31'b0, owner}, 32'd0);
        chk("sv_ho_bus_mode", {30'b0, bus_mode}, 32'd0);
        chk("sv_ho_cpu_stall", {31'b0, cpu_stall}, 32'd1);
        tick();
        chk("sv_cpu_owner", {31'b0, owner}, 32'd0);
        chk("sv_cpu_stall_lo", {31'b0, cpu_stall}, 32'd0);
        chk("sv_cpu_bus_mode", {30'b0, bus_mode}, 32'd2);
        chk("sv_cpu_bus_addr", bus_address, 32'h500);

        // Debug still requesting: it takes the bus straight back after the CPU write.
        tick();
        chk("rt_ho_owner", {31'b0, owner}, 32'd0);
        tick();
        dbg_halted = 1'b1; dbg_mode = 2'b00; cpu_mode = 2'b01;
        #1;
        chk("hh_owner0", {31'b0, owner}, 32'd1);

        // Halted hold: debug idle and CPU waiting for 200 cycles.
        for (int i = 0; i < 200; i++) begin
            tick();
            chk("hh_owner", {31'b0, owner}, 32'd1);
            chk("hh_cpu_stall", {31'b0, cpu_stall}, 32'd1);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            dbg_halted = 1'b0;
            #1;
            chk("hh_rel_owner", {31'b0, owner}, 32'd1);
        end
        tick();
        chk("hh_ho_owner", {31'b0, owner}, 32'd0);
        chk("hh_ho_cpu_stall", {31'b0, cpu_stall}, 32'd1);
        tick();
        chk("hh_cpu_owner", {31'b0, owner}, 32'd0);
        chk("hh_cpu_stall_lo", {31'b0, cpu_stall}, 32'd0);

        // CPU read in progress; halting the CPU hands over after its final read cycle.
        dbg_halted = 1'b1;
        tick();
        chk("ar_rd2_owner", {31'b0, owner}, 32'd0);
        tick();
        chk("ar_ho_owner", {31'b0, owner}, 32'd0);
        tick();
        chk("ar_dbg_owner", {31'b0, owner}, 32'd1);

        // Asynchronous reset in the middle of a debug-owned cycle.
        #2;
        reset = 1'b1;
        #1;
        chk("ar_owner", {31'b0, owner}, 32'd0);
        chk("ar_grant", {31'b0, dbg_grant}, 32'd0);
        chk("ar_bus_mode", {30'b0, bus_mode}, 32'd1);
        chk("ar_cpu_stall", {31'b0, cpu_stall}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
